// File: rtl/cplx_convcor_pkg.sv
// Shared types and helpers for the complex convolution/correlation engine.
// Mode codes, FSM states, output width rule and {re, im} pack/unpack.
package cplx_convcor_pkg;

  localparam logic MODE_CONV = 1'b0;
  localparam logic MODE_CORR = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    CALC
  } state_t;

  // Widest single component the pack/unpack helpers handle.
  localparam int MAXW = 32;

  function automatic int out_width(input int dw, input int n);
    return 2 * dw + 1 + $clog2(n);
  endfunction

  // Sign-extended real part of a {re, im} word of w-bit components.
  function automatic logic signed [MAXW-1:0] cplx_re(
    input logic [2*MAXW-1:0] v,
    input int                w
  );
    logic signed [2*MAXW-1:0] t;
    t = signed'(v << (2 * MAXW - 2 * w));
    return MAXW'(t >>> (2 * MAXW - w));
  endfunction

  // Sign-extended imaginary part of a {re, im} word.
  function automatic logic signed [MAXW-1:0] cplx_im(
    input logic [2*MAXW-1:0] v,
    input int                w
  );
    logic signed [2*MAXW-1:0] t;
    t = signed'(v << (2 * MAXW - w));
    return MAXW'(t >>> (2 * MAXW - w));
  endfunction

  // Packs the low w bits of re and im as {re, im}.
  function automatic logic [2*MAXW-1:0] cplx_pack(
    input logic signed [MAXW-1:0] re,
    input logic signed [MAXW-1:0] im,
    input int                     w
  );
    logic [2*MAXW-1:0] m;
    m = {(2 * MAXW){1'b1}} >> (2 * MAXW - w);
    return ((((2 * MAXW)'(re)) & m) << w) |
           (((2 * MAXW)'(im)) & m);
  endfunction

endpackage

// File: rtl/cplx_convcor_n_mac.sv
// Time-shared complex MAC: one product per cycle, optional conj(b), gated term.
// Ports: clk, i_rst, i_en, i_last (clear after add), i_conj, i_gate, i_a, i_b, o_sum.
module cplx_mac
  import cplx_convcor_pkg::*;
#(
  parameter int DW = 8,
  parameter int OW = 19
) (
  input  logic            clk,
  input  logic            i_rst,
  input  logic            i_en,
  input  logic            i_last,
  input  logic            i_conj,
  input  logic            i_gate,
  input  logic [2*DW-1:0] i_a,
  input  logic [2*DW-1:0] i_b,
  output logic [2*OW-1:0] o_sum
);

  logic signed [DW-1:0]   w_ar, w_ai, w_br, w_bi;
  logic signed [2*DW-1:0] w_rr, w_ii, w_ri, w_ir;
  logic signed [OW-1:0]   w_tre, w_tim;
  logic signed [OW-1:0]   w_sre, w_sim;
  logic signed [OW-1:0]   r_acc_re, r_acc_im;

  assign w_ar = DW'(cplx_re((2 * MAXW)'(i_a), DW));
  assign w_ai = DW'(cplx_im((2 * MAXW)'(i_a), DW));
  assign w_br = DW'(cplx_re((2 * MAXW)'(i_b), DW));
  assign w_bi = DW'(cplx_im((2 * MAXW)'(i_b), DW));

  assign w_rr = (2 * DW)'(w_ar) * (2 * DW)'(w_br);
  assign w_ii = (2 * DW)'(w_ai) * (2 * DW)'(w_bi);
  assign w_ri = (2 * DW)'(w_ar) * (2 * DW)'(w_bi);
  assign w_ir = (2 * DW)'(w_ai) * (2 * DW)'(w_br);

  // Conjugation folds into the signs of the bi products, so -bi
  // never has to be formed at DW bits (where -(-2^(DW-1)) overflows).
  always_comb begin
    w_tre = '0;
    w_tim = '0;
    if (i_gate) begin
      if (i_conj) begin
        w_tre = OW'(w_rr) + OW'(w_ii);
        w_tim = OW'(w_ir) - OW'(w_ri);
      end else begin
        w_tre = OW'(w_rr) - OW'(w_ii);
        w_tim = OW'(w_ri) + OW'(w_ir);
      end
    end
  end

  assign w_sre = r_acc_re + w_tre;
  assign w_sim = r_acc_im + w_tim;

  always_ff @(posedge clk) begin
    if (i_rst || (i_en && i_last)) begin
      r_acc_re <= '0;
      r_acc_im <= '0;
    end else if (i_en) begin
      r_acc_re <= w_sre;
      r_acc_im <= w_sim;
    end
  end

  assign o_sum = (2 * OW)'(cplx_pack(MAXW'(w_sre), MAXW'(w_sim), OW));

endmodule

// File: rtl/cplx_convcor_n.sv
// Complex convolution / full-lag cross-correlation over two N-sample sequences.
// Ports: clk, rst_n (sync, active-high), in_valid/in_a/in_b/in_mode/in_ready, out_valid/out.
module cplx_convcor_n
  import cplx_convcor_pkg::*;
#(
  parameter int N  = 3,
  parameter int DW = 8,
  parameter int OW = out_width(DW, N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  input  logic [2*DW-1:0] in_a,
  input  logic [2*DW-1:0] in_b,
  input  logic            in_mode,
  output logic            in_ready,
  output logic            out_valid,
  output logic [2*OW-1:0] out
);

  localparam int CW = $clog2(2 * N);
  localparam logic [CW-1:0] K_LAST = CW'(N - 1);
  localparam logic [CW-1:0] N_LAST = CW'(2 * N - 2);
  localparam logic signed [CW+1:0] S_NM1 = (CW + 2)'(N - 1);
  localparam logic signed [CW+1:0] S_N = (CW + 2)'(N);

  state_t          r_state;
  logic [CW-1:0]   r_cnt, r_n, r_k;
  logic            r_mode;
  logic            r_vld;
  logic [2*OW-1:0] r_out;
  logic [2*DW-1:0] r_a [N];
  logic [2*DW-1:0] r_b [N];

  logic signed [CW+1:0] w_n, w_k, w_ia, w_ib;
  logic                 w_gate, w_calc, w_last_k, w_beat;
  logic [2*DW-1:0]      w_sa, w_sb;
  logic [2*OW-1:0]      w_sum;

  assign w_calc   = (r_state == CALC);
  assign w_last_k = (r_k == K_LAST);
  assign w_beat   = in_valid && !w_calc;
  assign w_n      = signed'({2'b00, r_n});
  assign w_k      = signed'({2'b00, r_k});

  // Correlation uses a[k+l] with l = n-(N-1); out-of-range pairs gate to 0.
  always_comb begin
    w_ia = w_k;
    w_ib = w_n - w_k;
    if (r_mode != MODE_CONV) begin
      w_ia = w_n + w_k - S_NM1;
      w_ib = w_k;
    end
  end

  assign w_gate = !w_ia[CW+1] && (w_ia < S_N) &&
                  !w_ib[CW+1] && (w_ib < S_N);

  always_comb begin
    w_sa = '0;
    w_sb = '0;
    for (int i = 0; i < N; i++) begin
      if (w_ia == (CW + 2)'(i)) w_sa = r_a[i];
      if (w_ib == (CW + 2)'(i)) w_sb = r_b[i];
    end
  end

  cplx_mac #(
    .DW(DW),
    .OW(OW)
  ) u_mac (
    .clk   (clk),
    .i_rst (rst_n),
    .i_en  (w_calc),
    .i_last(w_last_k),
    .i_conj(r_mode == MODE_CORR),
    .i_gate(w_gate),
    .i_a   (w_sa),
    .i_b   (w_sb),
    .o_sum (w_sum)
  );

  always_ff @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (w_beat && (r_cnt == CW'(i))) begin
        r_a[i] <= in_a;
        r_b[i] <= in_b;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_n     <= '0;
      r_k     <= '0;
      r_mode  <= MODE_CONV;
      r_vld   <= 1'b0;
      r_out   <= '0;
    end else begin
      r_vld <= 1'b0;
      r_out <= '0;
      unique case (r_state)
        IDLE, LOAD: begin
          if (in_valid) begin
            if (r_state == IDLE) r_mode <= in_mode;
            if (r_cnt == K_LAST) begin
              r_cnt   <= '0;
              r_state <= CALC;
            end else begin
              r_cnt   <= r_cnt + CW'(1);
              r_state <= LOAD;
            end
          end
        end
        CALC: begin
          if (w_last_k) begin
            r_k   <= '0;
            r_vld <= 1'b1;
            r_out <= w_sum;
            if (r_n == N_LAST) begin
              r_n     <= '0;
              r_state <= IDLE;
            end else begin
              r_n <= r_n + CW'(1);
            end
          end else begin
            r_k <= r_k + CW'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready  = !w_calc;
  assign out_valid = r_vld;
  assign out       = r_out;

endmodule

// File: tb/tb_cplx_convcor_n.sv
// Scoreboard bench for cplx_convcor_n: driver pushes expected results,
// a negedge monitor pops and compares value and arrival cycle.
module tb_cplx_convcor_n;

  localparam int N    = 3;
  localparam int DW   = 8;
  localparam int OW   = 2 * DW + 1 + $clog2(N);
  localparam int NRES = 2 * N - 1;

  typedef int vec_t [N];
  typedef struct {
    longint re;
    longint im;
    int     at;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic            in_valid = 1'b0;
  logic            in_mode = 1'b0;
  logic [2*DW-1:0] in_a = '0;
  logic [2*DW-1:0] in_b = '0;
  logic            in_ready;
  logic            out_valid;
  logic [2*OW-1:0] out;

  cplx_convcor_n #(
    .N (N),
    .DW(DW),
    .OW(OW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_mode  (in_mode),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out      (out)
  );

  always #5 clk = ~clk;

  int   cyc = 0;
  int   nvec = 0;
  int   nerr = 0;
  int   lowrun = 0;
  bit   skip_rdy = 1'b0;
  exp_t q[$];
  exp_t me;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic longint sx(input logic [OW-1:0] v);
    return longint'(signed'(v));
  endfunction

  task automatic chk(input string nm, input longint act, input longint exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    if (!rst_n) begin
      if (out_valid) begin
        if (q.size() == 0) begin
          chk("unexpected_pulse", 1, 0);
        end else begin
          me = q.pop_front();
          chk("out_re", sx(out[2*OW-1:OW]), me.re);
          chk("out_im", sx(out[OW-1:0]), me.im);
          chk("pulse_cycle", cyc, me.at);
        end
      end else begin
        chk("out_zero_when_idle", (out == '0) ? 0 : 1, 0);
      end
      if (!in_ready) begin
        lowrun++;
      end else if (lowrun > 0) begin
        if (!skip_rdy) chk("ready_low_run", lowrun, NRES * N);
        skip_rdy = 1'b0;
        lowrun   = 0;
      end
    end
  end

  // Reference: direct sums over all index pairs that exist.
  task automatic model(input bit mode, input vec_t ar, input vec_t ai,
                       input vec_t br, input vec_t bi, input int e0);
    exp_t e;
    for (int n = 0; n < NRES; n++) begin
      e.re = 0;
      e.im = 0;
      e.at = e0 + (n + 1) * N;
      for (int k = 0; k < N; k++) begin
        if (!mode) begin
          int j;
          j = n - k;
          if (j >= 0 && j < N) begin
            e.re += longint'(ar[k]) * br[j] - longint'(ai[k]) * bi[j];
            e.im += longint'(ar[k]) * bi[j] + longint'(ai[k]) * br[j];
          end
        end else begin
          int i;
          i = k + n - (N - 1);
          if (i >= 0 && i < N) begin
            e.re += longint'(ar[i]) * br[k] + longint'(ai[i]) * bi[k];
            e.im += longint'(ai[i]) * br[k] - longint'(ar[i]) * bi[k];
          end
        end
      end
      q.push_back(e);
    end
  endtask

  task automatic run_job(input bit mode, input vec_t ar, input vec_t ai,
                         input vec_t br, input vec_t bi,
                         input int gap, input bit noise);
    int e0;
    e0 = 0;
    for (int i = 0; i < N; i++) begin
      int guard;
      guard = 0;
      forever begin
        @(negedge clk);
        if (gap > 0 && $urandom_range(99) < gap) begin
          in_valid = 1'b0;
          in_mode  = 1'($urandom);
          continue;
        end
        if (!in_ready) begin
          in_valid = 1'b0;
          guard++;
          if (guard > 200) begin
            nerr++;
            $display("FAIL ready_timeout: in_ready stuck low, expected high");
            $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
            $fatal(1);
          end
          continue;
        end
        break;
      end
      in_valid = 1'b1;
      in_a     = {DW'(ar[i]), DW'(ai[i])};
      in_b     = {DW'(br[i]), DW'(bi[i])};
      in_mode  = (i == 0) ? mode : ~mode;
      e0       = cyc + 1;
    end
    model(mode, ar, ai, br, bi, e0);
    if (noise) begin
      for (int c = 0; c < NRES * N - 1; c++) begin
        @(negedge clk);
        in_valid = 1'($urandom);
        in_mode  = 1'($urandom);
        in_a     = (2 * DW)'($urandom);
        in_b     = (2 * DW)'($urandom);
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (q.size() != 0 && g < 500) begin
      @(negedge clk);
      g++;
    end
    chk("drain_pending", q.size(), 0);
  endtask

  function automatic vec_t rnd();
    vec_t v;
    logic signed [DW-1:0] t;
    for (int i = 0; i < N; i++) begin
      t    = DW'($urandom);
      v[i] = int'(t);
    end
    return v;
  endfunction

  vec_t z, one, a1, b2r, b2i, c1, m1, va, vb, vc, vd;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit, expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $fatal(1);
  end

  initial begin
    z   = '{0, 0, 0};
    one = '{1, 1, 1};
    a1  = '{1, 2, 3};
    b2r = '{2, 0, 0};
    b2i = '{-1, 0, 0};
    c1  = '{1, 0, 0};
    m1  = '{-128, -128, -128};

    repeat (3) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out", (out == '0) ? 0 : 1, 0);
    chk("rst_in_ready", in_ready, 1);
    rst_n = 1'b0;

    run_job(0, a1, z, one, z, 0, 0);
    drain();
    run_job(0, c1, c1, b2r, b2i, 0, 0);
    drain();
    vd = '{0, 0, 1};
    run_job(1, c1, z, vd, z, 0, 0);
    drain();
    run_job(1, one, one, one, one, 0, 0);
    drain();
    run_job(0, m1, m1, m1, m1, 0, 0);
    drain();
    run_job(1, m1, m1, m1, m1, 0, 0);
    drain();
    run_job(0, a1, z, one, z, 50, 0);
    drain();
    run_job(0, a1, z, one, z, 0, 1);
    drain();

    // Reset in the middle of CALC.
    run_job(0, a1, a1, one, one, 0, 0);
    repeat (N + 2) @(negedge clk);
    #1;
    rst_n = 1'b1;
    q.delete();
    skip_rdy = 1'b1;
    @(negedge clk);
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_out", (out == '0) ? 0 : 1, 0);
    chk("midrst_in_ready", in_ready, 1);
    rst_n = 1'b0;
    repeat (3 * N * N) @(negedge clk);

    // Back-to-back: second job's first beat lands in the final pulse cycle.
    va = rnd(); vb = rnd(); vc = rnd(); vd = rnd();
    run_job(1, va, vb, vc, vd, 0, 0);
    run_job(0, a1, z, one, z, 0, 0);
    drain();

    for (int j = 0; j < 20; j++) begin
      va = rnd(); vb = rnd(); vc = rnd(); vd = rnd();
      run_job(1'($urandom), va, vb, vc, vd,
              ($urandom_range(1) == 1) ? 30 : 0, (j % 3) == 0);
      if ($urandom_range(1) == 1) drain();
    end
    drain();
    repeat (2 * N) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/cplx_convcor_n.md
Name: cplx_convcor_n

Overview:
Parametrised complex convolution/correlation engine. Loads two N-sample complex sequences beat by beat, then streams 2N-1 exact results through one time-shared complex MAC. Mode 0 is linear convolution. Mode 1 is full-lag cross-correlation a·conj(b). Sits in the Lab DSP datapath between the sample loader and the result checker.

Parameters:
N, 3, sequence length in samples (N >= 1)
DW, 8, signed width of each real/imag input component
OW, 2*DW+1+$clog2(N) (19 at defaults), signed width of each output component; values below this are unsupported

Ports:
clk  in  1  clock; all logic on rising edge
rst_n  in  1  synchronous reset, active-high (1 = reset asserted)
in_valid  in  1  input beat qualifier
in_a  in  2*DW  sample a[k] = {re, im}, two's complement
in_b  in  2*DW  sample b[k] = {re, im}, two's complement
in_mode  in  1  0 = convolution, 1 = correlation; sampled on first beat only
in_ready  out  1  high when a beat can be accepted
out_valid  out  1  one-cycle pulse per result
out  out  2*OW  result {re, im}, two's complement

Behaviour:
- Reset (rst_n=1 at clock edge): state IDLE, beat count 0, accumulator 0, out_valid=0, out=0, in_ready=1. Reset mid-LOAD or mid-CALC discards all partial data.
- FSM states: IDLE, LOAD, CALC.
  - IDLE: in_ready=1. A beat (in_valid & in_ready) stores a[0]/b[0] and latches in_mode, then goes to LOAD. For N=1 it goes straight to CALC.
  - LOAD: in_ready=1. Each beat stores the next sample. Gaps in in_valid are allowed and the count holds. The N-th beat moves the FSM to CALC.
  - CALC: in_ready=0. in_valid is ignored and no sample storage changes.
- CALC schedule:
  - Outer index n = 0..2N-2; inner k = 0..N-1. One MAC term per cycle, so each result takes exactly N cycles.
  - Conv term: a[k]·b[n-k]. Corr term (lag l = n-(N-1)): a[k+l]·conj(b[k]).
  - Any term with an out-of-range index contributes 0. It still consumes its cycle.
  - On the edge that ends k=N-1, out <= acc + term, out_valid <= 1, and acc clears.
- Latency: result n has out_valid high in the cycle beginning (n+1)·N edges after the edge that sampled the final beat. 2N-1 pulses total, spaced N cycles apart; contiguous when N=1.
- out equals 0 in every cycle where out_valid=0.
- Arithmetic:
  - Full-precision complex product: re = ar·br - ai·bi, im = ar·bi + ai·br. Conj(b) negates bi.
  - Accumulate at OW bits with sign extension. No saturation or rounding; results are exact by construction of OW.
- End of job: the FSM returns to IDLE on the edge that raises the final out_valid. in_ready is therefore 1 during that final pulse cycle, and a beat presented then is accepted as a[0] of the next job.
- in_mode changes while not on a first beat have no effect.

Decomposition:
- Package cplx_convcor_pkg holds:
  - mode constants MODE_CONV=0, MODE_CORR=1
  - state encoding IDLE/LOAD/CALC
  - function out_width(DW,N) returning 2*DW+1+$clog2(N)
  - helpers to pack/unpack {re, im}
- Sub-module cplx_mac: one complex multiplier with a conj_b control, an accumulator with clear and enable, and an in-range gate that forces the term to zero. The top level owns the sample storage, the indices and the FSM.

Test Plan:
1. N=3, mode 0, a=[1,2,3], b=[1,1,1] (imag 0) -> 5 pulses re=[1,3,6,5,3], im=0, spaced 3 cycles; first pulse 3 edges after the last beat.
2. Mode 0, a=[1+1j,0,0], b=[2-1j,0,0] -> first result 3+1j, remaining four results 0+0j.
3. Mode 1, a=[1,0,0], b=[0,0,1] -> lag order -2..2 gives [1,0,0,0,0]. Then a=b=[1+1j]×3 -> re=[2,4,6,4,2], im=0.
4. All components -128, N=3:
   - mode 0 -> im=[32768,65536,98304,65536,32768], re=0
   - mode 1 -> re=[32768,65536,98304,65536,32768], im=0
   - no overflow at OW=19
5. Robustness:
   - in_valid gaps during LOAD -> same results as test 1
   - in_valid pulsed and in_mode toggled during CALC -> ignored
   - rst_n=1 mid-CALC -> next cycle out_valid=0, out=0, in_ready=1, no further pulses
6. Back-to-back jobs: beat presented during the final out_valid cycle is accepted. The second job's results match an isolated run, with in_ready low for exactly (2N-1)·N cycles.
